// File: rtl/mem_pkg.sv
// mem_pkg: shared constants for the memory stage.
//   funct3 load/store size+sign codes, FSM state type, byte-lane masks,
//   and helpers for lane mask and alignment.
package mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    m = MASK_D;
    if (size == LB[1:0])      m = MASK_B;
    else if (size == LH[1:0]) m = MASK_H;
    else if (size == LW[1:0]) m = MASK_W;
    return m;
  endfunction

  function automatic logic is_aligned(input logic [2:0] addr, input logic [1:0] size);
    logic ok;
    ok = (addr == 3'b000);
    if (size == LB[1:0])      ok = 1'b1;
    else if (size == LH[1:0]) ok = (addr[0] == 1'b0);
    else if (size == LW[1:0]) ok = (addr[1:0] == 2'b00);
    return ok;
  endfunction

endpackage

// File: rtl/mem_stage_dmem_ctrl_load_extend.sv
// mem_load_extend: selects the addressed lanes of a read doubleword and
// sign/zero-extends them to 64 bits.
//   dmem_rdata : read doubleword
//   addr       : byte offset within the doubleword
//   funct3     : load size/sign code
//   load_data  : extended result
module mem_load_extend
  import mem_pkg::*;
(
  input  logic [63:0] dmem_rdata,
  input  logic [2:0]  addr,
  input  logic [2:0]  funct3,
  output logic [63:0] load_data
);

  logic [63:0] shifted;

  always_comb begin
    shifted   = dmem_rdata >> {addr, 3'b000};
    load_data = shifted;
    unique case (funct3)
      LB:      load_data = {{56{shifted[7]}},  shifted[7:0]};
      LH:      load_data = {{48{shifted[15]}}, shifted[15:0]};
      LW:      load_data = {{32{shifted[31]}}, shifted[31:0]};
      LD:      load_data = shifted;
      LBU:     load_data = {56'b0, shifted[7:0]};
      LHU:     load_data = {48'b0, shifted[15:0]};
      LWU:     load_data = {32'b0, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_dmem_ctrl.sv
// mem_stage_dmem_ctrl: MEM stage; turns EX/MEM load/store controls into a
// req/ack transaction on a 64-bit data port, stalls upstream until ack,
// and registers the MEM/WB results.
//   clock, reset_n           : clock, async active-low reset
//   i_*                      : EX/MEM register outputs
//   dmem_req/we/addr/wdata/wstrb, dmem_ack/rdata : data-memory port
//   stall, pc_src            : combinational pipeline controls
//   wb_*                     : MEM/WB register
//   misalign_err             : one-cycle error pulse
// Optional: MEM_TIMEOUT_EN abandons a WAIT after TIMEOUT_CYCLES un-acked cycles.
module mem_stage_dmem_ctrl
  import mem_pkg::*;
#(
  parameter int DMEM_ADDR_W    = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   i_MemRead,
  input  logic                   i_MemWrite,
  input  logic                   i_MemtoReg,
  input  logic                   i_RegWrite,
  input  logic                   i_Branch,
  input  logic                   i_Zero,
  input  logic                   i_Jump,
  input  logic [2:0]             i_funct3,
  input  logic [63:0]            i_alu_result,
  input  logic [63:0]            i_store_data,
  input  logic [4:0]             i_rd,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [DMEM_ADDR_W-1:0] dmem_addr,
  output logic [63:0]            dmem_wdata,
  output logic [7:0]             dmem_wstrb,
  input  logic                   dmem_ack,
  input  logic [63:0]            dmem_rdata,
  output logic                   stall,
  output logic                   pc_src,
  output logic                   wb_RegWrite,
  output logic                   wb_MemtoReg,
  output logic [63:0]            wb_read_data,
  output logic [63:0]            wb_alu_result,
  output logic [4:0]             wb_rd,
  output logic                   misalign_err
);

  mem_state_e  state, state_n;
  logic        memop, aligned;
  logic [7:0]  wstrb_n;
  logic [63:0] wdata_n;
  logic [63:0] load_data;
  logic        timeout;
  logic        start_req, finish, drop, capture, capture_err;

  assign memop   = i_MemRead | i_MemWrite;
  assign aligned = is_aligned(i_alu_result[2:0], i_funct3[1:0]);
  assign wstrb_n = size_mask(i_funct3[1:0]) << i_alu_result[2:0];
  assign wdata_n = i_store_data << {i_alu_result[2:0], 3'b000};
  assign pc_src  = (i_Branch & i_Zero) | i_Jump;

  // EX/MEM is frozen while stalled, so its address/funct3 stay valid at ack.
  mem_load_extend u_load_extend (
    .dmem_rdata (dmem_rdata),
    .addr       (i_alu_result[2:0]),
    .funct3     (i_funct3),
    .load_data  (load_data)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                        wait_cnt <= '0;
    else if (start_req)                  wait_cnt <= '0;
    else if (state == WAIT && !dmem_ack) wait_cnt <= wait_cnt + CNT_W'(1);
  end

  assign timeout = (state == WAIT) && !dmem_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n     = state;
    stall       = 1'b0;
    start_req   = 1'b0;
    finish      = 1'b0;
    drop        = 1'b0;
    capture     = 1'b0;
    capture_err = 1'b0;
    unique case (state)
      IDLE: begin
        if (!memop) begin
          capture = 1'b1;
        end else if (aligned) begin
          stall     = 1'b1;
          start_req = 1'b1;
          state_n   = WAIT;
        end else begin
          capture_err = 1'b1;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          finish  = 1'b1;
          state_n = IDLE;
        end else if (timeout) begin
          drop    = 1'b1;
          state_n = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Reset releases upstream immediately, even with a memop still presented.
    stall = stall & reset_n;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      dmem_wstrb    <= '0;
      wb_RegWrite   <= 1'b0;
      wb_MemtoReg   <= 1'b0;
      wb_read_data  <= '0;
      wb_alu_result <= '0;
      wb_rd         <= '0;
      misalign_err  <= 1'b0;
    end else begin
      if (start_req) begin
        dmem_req   <= 1'b1;
        dmem_we    <= i_MemWrite;
        dmem_addr  <= {i_alu_result[DMEM_ADDR_W-1:3], 3'b000};
        dmem_wstrb <= i_MemWrite ? wstrb_n : '0;
        dmem_wdata <= i_MemWrite ? wdata_n : '0;
      end else if (finish || drop) begin
        dmem_req <= 1'b0;
      end

      if (capture || capture_err || finish) begin
        wb_RegWrite   <= i_RegWrite & ~capture_err;
        wb_MemtoReg   <= i_MemtoReg;
        wb_alu_result <= i_alu_result;
        wb_rd         <= i_rd;
        wb_read_data  <= (finish && i_MemRead) ? load_data : '0;
      end else begin
        wb_RegWrite   <= 1'b0;
        wb_MemtoReg   <= 1'b0;
        wb_alu_result <= '0;
        wb_rd         <= '0;
        wb_read_data  <= '0;
      end

      misalign_err <= capture_err | drop;
    end
  end

endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
`timescale 1ns/1ps
module tb_mem_stage_dmem_ctrl;
  import mem_pkg::*;

`ifdef MEM_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 255;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        i_MemRead, i_MemWrite, i_MemtoReg, i_RegWrite;
  logic        i_Branch, i_Zero, i_Jump;
  logic [2:0]  i_funct3;
  logic [63:0] i_alu_result, i_store_data;
  logic [4:0]  i_rd;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        stall, pc_src;
  logic        wb_RegWrite, wb_MemtoReg;
  logic [63:0] wb_read_data, wb_alu_result;
  logic [4:0]  wb_rd;
  logic        misalign_err;

  always #5 clock = ~clock;

  mem_stage_dmem_ctrl #(.DMEM_ADDR_W(64), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clock(clock), .reset_n(reset_n),
    .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite), .i_MemtoReg(i_MemtoReg), .i_RegWrite(i_RegWrite),
    .i_Branch(i_Branch), .i_Zero(i_Zero), .i_Jump(i_Jump),
    .i_funct3(i_funct3), .i_alu_result(i_alu_result), .i_store_data(i_store_data), .i_rd(i_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .pc_src(pc_src),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_read_data(wb_read_data),
    .wb_alu_result(wb_alu_result), .wb_rd(wb_rd), .misalign_err(misalign_err)
  );

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic [63:0] rdata;
    logic [63:0] alu;
    logic [4:0]  rd;
  } wb_t;

  wb_t sb[$];
  int  checks   = 0;
  int  failures = 0;

  // results of the most recent run_txn
  int          n_stall, n_rd;
  logic        s_req, s_we, timed_out;
  logic [63:0] s_addr, s_wdata;
  logic [7:0]  s_wstrb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd_en, input logic wr_en, input logic m2r, input logic rw,
                       input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] sdata,
                       input logic [4:0] rd);
    i_MemRead    = rd_en;
    i_MemWrite   = wr_en;
    i_MemtoReg   = m2r;
    i_RegWrite   = rw;
    i_funct3     = f3;
    i_alu_result = addr;
    i_store_data = sdata;
    i_rd         = rd;
  endtask

  task automatic expect_wb(input logic rw, input logic m2r, input logic [63:0] rdata,
                           input logic [63:0] alu, input logic [4:0] rd);
    wb_t e;
    e.rw = rw; e.m2r = m2r; e.rdata = rdata; e.alu = alu; e.rd = rd;
    sb.push_back(e);
  endtask

  task automatic check_wb(input string tag);
    wb_t e;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL %s.sb observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".wb_RegWrite"},   64'(wb_RegWrite), 64'(e.rw));
      chk({tag, ".wb_MemtoReg"},   64'(wb_MemtoReg), 64'(e.m2r));
      chk({tag, ".wb_read_data"},  wb_read_data,     e.rdata);
      chk({tag, ".wb_alu_result"}, wb_alu_result,    e.alu);
      chk({tag, ".wb_rd"},         64'(wb_rd),       64'(e.rd));
    end
  endtask

  // Entered at posedge+1 with the instruction driven. Cycle c=0 is the IDLE
  // cycle; ack (if ack_after >= 0) is raised in WAIT cycle ack_after+1.
  // Returns at posedge+1 after the edge on which stall was low.
  task automatic run_txn(input int ack_after, input logic [63:0] rdata);
    logic st;
    n_stall = 0; n_rd = 0; timed_out = 1'b1;
    s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
    for (int c = 0; c < 64; c++) begin
      dmem_ack   = (ack_after >= 0) && (c == ack_after + 1);
      dmem_rdata = rdata;
      @(negedge clock);
      st = stall;
      if (st) n_stall++;
      if (c >= 1 && wb_rd != 5'd0) n_rd++;
      if (c == 1) begin
        s_req = dmem_req; s_we = dmem_we; s_addr = dmem_addr;
        s_wdata = dmem_wdata; s_wstrb = dmem_wstrb;
      end
      @(posedge clock); #1;
      if (!st) begin
        timed_out = 1'b0;
        break;
      end
    end
    dmem_ack = 1'b0;
    if (wb_rd != 5'd0) n_rd++;
    chk("txn_bound", 64'(timed_out), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    i_Branch = 1'b0; i_Zero = 1'b0; i_Jump = 1'b0;
    drive(0, 0, 0, 0, LB, 64'h0, 64'h0, 5'd0);

    // reset state
    #12;
    chk("rst.dmem_req",     64'(dmem_req), 64'd0);
    chk("rst.dmem_we",      64'(dmem_we), 64'd0);
    chk("rst.dmem_addr",    dmem_addr, 64'd0);
    chk("rst.dmem_wstrb",   64'(dmem_wstrb), 64'd0);
    chk("rst.wb_RegWrite",  64'(wb_RegWrite), 64'd0);
    chk("rst.wb_rd",        64'(wb_rd), 64'd0);
    chk("rst.misalign_err", 64'(misalign_err), 64'd0);
    chk("rst.stall",        64'(stall), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // add x5: pass-through, latency 1
    drive(0, 0, 0, 1, LB, 64'h1234, 64'h0, 5'd5);
    expect_wb(1, 0, 64'h0, 64'h1234, 5'd5);
    run_txn(-1, 64'h0);
    chk("add.stall_cycles", 64'(n_stall), 64'd0);
    check_wb("add");

    // ld at 0x1000, ack after 3 WAIT cycles
    drive(1, 0, 1, 1, LD, 64'h1000, 64'h0, 5'd10);
    expect_wb(1, 1, 64'h1122334455667788, 64'h1000, 5'd10);
    run_txn(3, 64'h1122334455667788);
    chk("ld.stall_cycles", 64'(n_stall), 64'd4);
    chk("ld.dmem_req",     64'(s_req), 64'd1);
    chk("ld.dmem_we",      64'(s_we), 64'd0);
    chk("ld.dmem_addr",    s_addr, 64'h1000);
    chk("ld.nonzero_rd",   64'(n_rd), 64'd1);
    chk("ld.req_dropped",  64'(dmem_req), 64'd0);
    check_wb("ld");

    // lb / lbu at 0x1007, top byte 0x80
    drive(1, 0, 1, 1, LB, 64'h1007, 64'h0, 5'd11);
    expect_wb(1, 1, 64'hFFFFFFFFFFFFFF80, 64'h1007, 5'd11);
    run_txn(0, 64'h8011223344556677);
    chk("lb.stall_cycles", 64'(n_stall), 64'd1);
    check_wb("lb");
    drive(1, 0, 1, 1, LBU, 64'h1007, 64'h0, 5'd11);
    expect_wb(1, 1, 64'h0000000000000080, 64'h1007, 5'd11);
    run_txn(1, 64'h8011223344556677);
    check_wb("lbu");

    // halfword / word sign and zero extension
    drive(1, 0, 1, 1, LH, 64'h4006, 64'h0, 5'd12);
    expect_wb(1, 1, 64'hFFFFFFFFFFFF8001, 64'h4006, 5'd12);
    run_txn(0, 64'h8001222233334444);
    check_wb("lh");
    drive(1, 0, 1, 1, LHU, 64'h4002, 64'h0, 5'd13);
    expect_wb(1, 1, 64'h000000000000F333, 64'h4002, 5'd13);
    run_txn(2, 64'h11112222F3334444);
    check_wb("lhu");
    drive(1, 0, 1, 1, LW, 64'h4004, 64'h0, 5'd14);
    expect_wb(1, 1, 64'hFFFFFFFFDEADBEEF, 64'h4004, 5'd14);
    run_txn(0, 64'hDEADBEEF01234567);
    check_wb("lw");
    drive(1, 0, 1, 1, LWU, 64'h4004, 64'h0, 5'd15);
    expect_wb(1, 1, 64'h00000000DEADBEEF, 64'h4004, 5'd15);
    run_txn(0, 64'hDEADBEEF01234567);
    check_wb("lwu");

    // sh at 0x2002
    drive(0, 1, 0, 0, 3'b001, 64'h2002, 64'h000000000000BEEF, 5'd3);
    expect_wb(0, 0, 64'h0, 64'h2002, 5'd3);
    run_txn(1, 64'hFFFFFFFFFFFFFFFF);
    chk("sh.dmem_req",   64'(s_req), 64'd1);
    chk("sh.dmem_we",    64'(s_we), 64'd1);
    chk("sh.dmem_addr",  s_addr, 64'h2000);
    chk("sh.dmem_wstrb", 64'(s_wstrb), 64'h0C);
    chk("sh.dmem_wdata", s_wdata, 64'h00000000BEEF0000);
    check_wb("sh");

    // sb at 0x2005, sd at 0x5000
    drive(0, 1, 0, 0, 3'b000, 64'h2005, 64'h00000000000000A5, 5'd0);
    expect_wb(0, 0, 64'h0, 64'h2005, 5'd0);
    run_txn(0, 64'h0);
    chk("sb.dmem_wstrb", 64'(s_wstrb), 64'h20);
    chk("sb.dmem_wdata", s_wdata, 64'h0000A50000000000);
    check_wb("sb");
    drive(0, 1, 0, 0, 3'b011, 64'h5000, 64'h0123456789ABCDEF, 5'd0);
    expect_wb(0, 0, 64'h0, 64'h5000, 5'd0);
    run_txn(0, 64'h0);
    chk("sd.dmem_wstrb", 64'(s_wstrb), 64'hFF);
    chk("sd.dmem_wdata", s_wdata, 64'h0123456789ABCDEF);
    check_wb("sd");

    // misaligned lw at 0x3002, then add x5
    drive(1, 0, 1, 1, LW, 64'h3002, 64'h0, 5'd7);
    expect_wb(0, 1, 64'h0, 64'h3002, 5'd7);
    run_txn(-1, 64'h0);
    chk("mis.stall_cycles", 64'(n_stall), 64'd0);
    chk("mis.dmem_req",     64'(dmem_req), 64'd0);
    chk("mis.misalign_err", 64'(misalign_err), 64'd1);
    check_wb("mis");
    drive(0, 0, 0, 1, LB, 64'h55, 64'h0, 5'd5);
    expect_wb(1, 0, 64'h0, 64'h55, 5'd5);
    run_txn(-1, 64'h0);
    chk("mis.err_pulse_end", 64'(misalign_err), 64'd0);
    check_wb("add2");

    // reset mid-WAIT, with pc_src checked while stalled
    drive(1, 0, 1, 1, LD, 64'h6000, 64'h0, 5'd12);
    @(posedge clock); #1;
    chk("rw.stall_in_wait", 64'(stall), 64'd1);
    chk("rw.req_in_wait",   64'(dmem_req), 64'd1);
    for (int k = 0; k < 8; k++) begin
      i_Branch = k[0]; i_Zero = k[1]; i_Jump = k[2];
      #1;
      chk($sformatf("pc_src.%0d", k), 64'(pc_src), 64'((k[0] & k[1]) | k[2]));
    end
    i_Branch = 1'b0; i_Zero = 1'b0; i_Jump = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rw.req_after_rst",   64'(dmem_req), 64'd0);
    chk("rw.stall_after_rst", 64'(stall), 64'd0);
    drive(0, 0, 0, 0, LB, 64'h0, 64'h0, 5'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 64'hFFFFFFFFFFFFFFFF;
    expect_wb(0, 0, 64'h0, 64'h0, 5'd0);
    @(posedge clock); #1;
    dmem_ack = 1'b0;
    chk("rw.late_ack_req", 64'(dmem_req), 64'd0);
    check_wb("late_ack");

`ifdef MEM_TIMEOUT_EN
    // no ack: abandoned after TO_CYC counted WAIT cycles
    drive(1, 0, 1, 1, LD, 64'h7000, 64'h0, 5'd9);
    expect_wb(0, 0, 64'h0, 64'h0, 5'd0);
    run_txn(-1, 64'h0);
    chk("to.stall_cycles", 64'(n_stall), 64'd5);
    chk("to.misalign_err", 64'(misalign_err), 64'd1);
    chk("to.dmem_req",     64'(dmem_req), 64'd0);
    check_wb("to");
    drive(0, 0, 0, 0, LB, 64'h0, 64'h0, 5'd0);
    expect_wb(0, 0, 64'h0, 64'h0, 5'd0);
    run_txn(-1, 64'h0);
    chk("to.err_once", 64'(misalign_err), 64'd0);
    check_wb("to_nop");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_dmem_ctrl.md
Name: mem_stage_dmem_ctrl

Overview:
- Memory stage of the 5-stage pipeline. Sits directly downstream of the EX/MEM registers and drives the MEM/WB boundary.
- Turns EX/MEM load/store controls into a request/acknowledge transaction on a 64-bit data-memory port, sized by funct3.
- Stalls upstream stages until the memory acknowledges. Registers the results that write-back needs.

Parameters:
- DMEM_ADDR_W, 64, width of dmem_addr (low bits of ALU result).
- TIMEOUT_CYCLES, 255, wait-cycle limit; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clock  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- i_MemRead, i_MemWrite, i_MemtoReg, i_RegWrite  in  1 each  EX/MEM control outputs
- i_Branch, i_Zero, i_Jump  in  1 each  EX/MEM branch info
- i_funct3  in  3  access size/sign
- i_alu_result  in  64  effective address or ALU value
- i_store_data  in  64  rs2 value for stores
- i_rd  in  5  destination register
- dmem_req  out  1  request valid (registered)
- dmem_we  out  1  1 = store
- dmem_addr  out  DMEM_ADDR_W  doubleword-aligned address, low 3 bits zero
- dmem_wdata  out  64  lane-shifted store data
- dmem_wstrb  out  8  byte enables
- dmem_ack  in  1  one-cycle completion pulse
- dmem_rdata  in  64  read doubleword, valid with ack
- stall  out  1  combinational; freezes PC, IF/ID, ID/EX, EX/MEM
- pc_src  out  1  combinational: (i_Branch & i_Zero) | i_Jump
- wb_RegWrite, wb_MemtoReg  out  1 each  MEM/WB controls
- wb_read_data, wb_alu_result  out  64 each  MEM/WB data
- wb_rd  out  5  MEM/WB destination
- misalign_err  out  1  one-cycle registered pulse

Behaviour:
- Reset: every registered output is 0 and the state is IDLE, including dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, all wb_* and misalign_err. Async assertion aborts any transaction. An ack arriving after reset is ignored.
- memop = i_MemRead | i_MemWrite.
- Size comes from funct3[1:0] (byte, half, word, double). funct3[2] selects zero-extension. Stores use funct3[1:0] only.
- An access is aligned when addr[2:0] is a multiple of the size.
- State IDLE:
  - No memop: MEM/WB captures the EX/MEM values; stall = 0. One-cycle latency.
  - Aligned memop: stall = 1 this cycle. Next edge: state WAIT; dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata loaded; MEM/WB gets a bubble (wb_RegWrite = 0, wb_rd = 0).
  - Misaligned memop: no request, stall = 0. MEM/WB captures with wb_RegWrite forced to 0. misalign_err = 1 for one cycle.
- State WAIT: stall = !dmem_ack. While waiting, MEM/WB gets bubbles and dmem_* are held stable.
  - On ack, same edge: dmem_req goes to 0; state returns to IDLE; MEM/WB captures, with wb_read_data = extended load data (stores: 0).
  - The EX/MEM register advances at that same edge, so the access never re-triggers.
- Store lanes: wstrb = size mask << addr[2:0]; wdata = store data << (8 × addr[2:0]).
- Load: shift dmem_rdata right by 8 × addr[2:0], then sign- or zero-extend from the access size to 64 bits.
- dmem_ack in IDLE is ignored.
- pc_src does not depend on stall or state.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8-bit or wider wait counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop dmem_req, return to IDLE, release stall, push a bubble into MEM/WB, and pulse misalign_err (shared error flag).
  - An ack in the same cycle as the timeout wins.
- Undefined: no counter; WAIT persists until ack.

Decomposition:
- Shared package mem_pkg: funct3 size/sign constants (LB = 3'b000 … LWU = 3'b110), IDLE/WAIT state encoding, byte-mask constants.
- One combinational sub-module mem_load_extend: inputs dmem_rdata, addr[2:0], funct3; output 64-bit extended result.

Test Plan:
- Reset mid-WAIT (reset_n low 1 cycle): dmem_req = 0 and stall = 0 immediately. A late ack does not write MEM/WB.
- ld at 0x1000, ack after 3 WAIT cycles with rdata 0x1122334455667788:
  - stall is high for 4 cycles, then wb_read_data = 0x1122334455667788 and wb_RegWrite = 1.
  - Exactly one nonzero wb_rd in the window.
- lb at 0x1007, rdata 0x80xxxxxxxxxxxxxx: wb_read_data = 0xFFFFFFFFFFFFFF80. Same access with lbu: 0x80.
- sh at 0x2002 with data 0xBEEF: dmem_wstrb = 8'b00001100, dmem_wdata[31:16] = 0xBEEF, dmem_we = 1, dmem_addr = 0x2000.
- lw at 0x3002: no dmem_req, misalign_err pulses, wb_RegWrite = 0, no stall. add x5 passes through with latency 1.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no ack: stall releases after 5 cycles and misalign_err pulses once.
